// File: rtl/sdio_cmd_rx.sv
// Purpose: receives 7-byte command frames (SYNC, cmd, arg[31:24..7:0], tail) from an RX byte FIFO.
// Latency: 3 cycles per byte; outputs and valid_o update in the cycle after the tail byte is captured.
// Backpressure: reads only while rxempty is low; an in-frame gap of TIMEOUT empty cycles drops the frame with err_o.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rxempty / rxen   FIFO empty flag in, one-cycle read strobe out
//   dat_i            FIFO read data, valid the cycle after rxen
//   cmd_o/arg_o/tail_o  fields of the last complete frame
//   valid_o / err_o  one-cycle pulses: new frame / partial frame discarded
module sdio_cmd_rx #(
    parameter logic [7:0] SYNC    = 8'hF0,
    parameter int         TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxempty,
    output logic        rxen,
    input  logic [7:0]  dat_i,
    output logic [7:0]  cmd_o,
    output logic [31:0] arg_o,
    output logic [7:0]  tail_o,
    output logic        valid_o,
    output logic        err_o
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    cmd_sh_q, cmd_sh_d;
    logic [31:0]   arg_sh_q, arg_sh_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   arg_q, arg_d;
    logic [7:0]    tail_q, tail_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          timeout;

    // ---------------- read FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- read FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ:  if (!rxempty) state_d = ST_WAIT;
            ST_WAIT: state_d = ST_CAP;
            ST_CAP:  state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase
    end

    // ---------------- read FSM: outputs ----------------
    // Strobe is combinational so it lands in the same cycle REQ sees data;
    // gated by rst so nothing is popped while the block is held in reset.
    always_comb begin
        rxen = (state_q == ST_REQ) && !rxempty && !rst;
    end

    // ---------------- frame assembly and gap timer ----------------
    // The timer only ever reaches T_MAX for one cycle, and only in REQ:
    // that cycle aborts the frame even if a read is launched in it, so
    // the byte being read starts a fresh hunt.
    assign timeout = (timer_q == T_MAX);

    always_comb begin
        idx_d    = idx_q;
        timer_d  = timer_q;
        cmd_sh_d = cmd_sh_q;
        arg_sh_d = arg_sh_q;
        cmd_d    = cmd_q;
        arg_d    = arg_q;
        tail_d   = tail_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (timeout) begin
            idx_d   = 3'd0;
            timer_d = '0;
        end else if (state_q == ST_CAP) begin
            timer_d = '0;
            case (idx_q)
                3'd0: begin
                    if (dat_i == SYNC) idx_d = 3'd1;
                end
                3'd1: begin
                    cmd_sh_d = dat_i;
                    idx_d    = 3'd2;
                end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    // MSB-first: after four shifts byte 2 sits in [31:24]
                    arg_sh_d = {arg_sh_q[23:0], dat_i};
                    idx_d    = idx_q + 3'd1;
                end
                3'd6: begin
                    cmd_d   = cmd_sh_q;
                    arg_d   = arg_sh_q;
                    tail_d  = dat_i;
                    valid_d = 1'b1;
                    idx_d   = 3'd0;
                end
                default: idx_d = 3'd0;
            endcase
        end else if ((state_q == ST_REQ) && rxempty && (idx_q != 3'd0)) begin
            timer_d = timer_q + 1'b1;
            // err_o is registered, so it rises together with timer_q == T_MAX
            if (timer_q == T_PRE) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= 3'd0;
            timer_q  <= '0;
            cmd_sh_q <= 8'h00;
            arg_sh_q <= 32'h0;
            cmd_q    <= 8'h00;
            arg_q    <= 32'h0;
            tail_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            cmd_sh_q <= cmd_sh_d;
            arg_sh_q <= arg_sh_d;
            cmd_q    <= cmd_d;
            arg_q    <= arg_d;
            tail_q   <= tail_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign cmd_o   = cmd_q;
    assign arg_o   = arg_q;
    assign tail_o  = tail_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_sdio_cmd_rx.sv
// Purpose: directed self-checking bench for sdio_cmd_rx with a byte-queue FIFO model.
// Latency: FIFO model pops on the edge that ends an rxen cycle; data is stable long before capture.
// Backpressure: 'hold' forces rxempty high to create inter-byte gaps.
module tb_sdio_cmd_rx;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxempty = 1'b1;
    logic        rxen;
    logic [7:0]  dat_i = 8'h00;
    logic [7:0]  cmd_o;
    logic [31:0] arg_o;
    logic [7:0]  tail_o;
    logic        valid_o;
    logic        err_o;

    always #5 clk = ~clk;

    sdio_cmd_rx #(.SYNC(8'hF0), .TIMEOUT(TO)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .rxempty (rxempty),
        .rxen    (rxen),
        .dat_i   (dat_i),
        .cmd_o   (cmd_o),
        .arg_o   (arg_o),
        .tail_o  (tail_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    logic [7:0]  fifo[$];
    logic        hold = 1'b0;
    logic        rxen_prev = 1'b0;
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;
    int          n_valid, n_err, n_rxen, first_rxen, last_rxen, first_valid, first_err;
    int          spacing_bad, bad_empty, bad_b2b;
    int          bad_both = 0;
    logic [7:0]  vcmd[$];
    logic [31:0] varg[$];
    logic [7:0]  vtail[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic clear_mon();
        n_valid = 0; n_err = 0; n_rxen = 0;
        first_rxen = -1; last_rxen = -1; first_valid = -1; first_err = -1;
        spacing_bad = 0; bad_empty = 0; bad_b2b = 0;
        vcmd.delete(); varg.delete(); vtail.delete();
    endtask

    // One clock: observe at negedge, apply FIFO effects 1ns after posedge.
    task automatic tick();
        @(negedge clk);
        if (rxen) begin
            if (rxempty) bad_empty++;
            if (rxen_prev) bad_b2b++;
            if (n_rxen > 0 && (cyc - last_rxen) != 3) spacing_bad++;
            if (n_rxen == 0) first_rxen = cyc;
            last_rxen = cyc;
            n_rxen++;
        end
        if (valid_o) begin
            if (n_valid == 0) first_valid = cyc;
            n_valid++;
            vcmd.push_back(cmd_o);
            varg.push_back(arg_o);
            vtail.push_back(tail_o);
        end
        if (err_o) begin
            if (n_err == 0) first_err = cyc;
            n_err++;
        end
        if (valid_o && err_o) bad_both++;
        rxen_prev = rxen;
        @(posedge clk);
        #1;
        cyc++;
        if (rxen_prev && fifo.size() > 0) dat_i = fifo.pop_front();
        rxempty = hold || (fifo.size() == 0);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fifo.push_back(v[i*8 +: 8]);
        rxempty = hold || (fifo.size() == 0);
    endtask

    task automatic chk_frame(input string tag, input int k, input logic [7:0] c,
                             input logic [31:0] a, input logic [7:0] t);
        if (vcmd.size() > k) begin
            chk({tag, "_cmd"}, {24'h0, vcmd[k]}, {24'h0, c});
            chk({tag, "_arg"}, varg[k], a);
            chk({tag, "_tail"}, {24'h0, vtail[k]}, {24'h0, t});
        end else begin
            chk({tag, "_present"}, vcmd.size(), k + 1);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cmd"},   {24'h0, cmd_o},  32'h0);
        chk({tag, "_arg"},   arg_o,           32'h0);
        chk({tag, "_tail"},  {24'h0, tail_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, valid_o}, 32'h0);
        chk({tag, "_err"},   {31'h0, err_o},   32'h0);
    endtask

    int gap_left;

    initial begin
        clear_mon();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk_zero_outputs("reset");

        // Single frame, FIFO never empty
        clear_mon();
        push_bytes(64'hF0_19_12_34_56_78_AA, 7);
        run(30);
        chk("t1_valid_cnt", n_valid, 1);
        chk("t1_valid_lat", first_valid - first_rxen, 21);
        chk_frame("t1", 0, 8'h19, 32'h12345678, 8'hAA);
        chk("t1_rxen_cnt", n_rxen, 7);
        chk("t1_rxen_spacing", spacing_bad, 0);
        chk("t1_err_cnt", n_err, 0);
        chk("t1_hold_cmd", {24'h0, cmd_o}, 32'h19);

        // Leading garbage dropped during hunt
        clear_mon();
        push_bytes(64'h00_FF_F1, 3);
        push_bytes(64'hF0_0D_00_00_00_01_55, 7);
        run(40);
        chk("t2_valid_cnt", n_valid, 1);
        chk_frame("t2", 0, 8'h0D, 32'h00000001, 8'h55);

        // SYNC value inside a frame is data
        clear_mon();
        push_bytes(64'hF0_12_F0_F0_00_00_00, 7);
        run(30);
        chk("t3_valid_cnt", n_valid, 1);
        chk_frame("t3", 0, 8'h12, 32'hF0F00000, 8'h00);

        // Gap timeout: 3 bytes then empty
        clear_mon();
        push_bytes(64'hF0_19_12, 3);
        run(60);
        chk("t4_err_cnt", n_err, 1);
        chk("t4_err_time", first_err - first_rxen, 25);
        chk("t4_valid_cnt", n_valid, 0);
        chk("t4_keep_cmd", {24'h0, cmd_o}, 32'h12);
        chk("t4_keep_arg", arg_o, 32'hF0F00000);
        chk("t4_keep_tail", {24'h0, tail_o}, 32'h00);
        clear_mon();
        push_bytes(64'hF0_33_DE_AD_BE_EF_77, 7);
        run(30);
        chk("t4b_valid_cnt", n_valid, 1);
        chk_frame("t4b", 0, 8'h33, 32'hDEADBEEF, 8'h77);

        // Reset in mid-frame
        clear_mon();
        push_bytes(64'hF0_19, 2);
        run(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outputs("t5_rst");
        push_bytes(64'hF0_44_01_02_03_04_99, 7);
        run(60);
        chk("t5_err_cnt", n_err, 0);
        chk("t5_valid_cnt", n_valid, 1);
        chk_frame("t5", 0, 8'h44, 32'h01020304, 8'h99);

        // Back-to-back frames with random short gaps
        clear_mon();
        push_bytes(64'hF0_11_A1_A2_A3_A4_B1, 7);
        push_bytes(64'hF0_22_C1_C2_C3_C4_B2, 7);
        gap_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (gap_left > 0) begin
                hold = 1'b1;
                gap_left--;
            end else begin
                hold = 1'b0;
                if ($urandom_range(0, 3) == 0) gap_left = $urandom_range(1, 10);
            end
            rxempty = hold || (fifo.size() == 0);
            tick();
        end
        hold = 1'b0;
        rxempty = (fifo.size() == 0);
        run(40);
        chk("t6_valid_cnt", n_valid, 2);
        chk_frame("t6a", 0, 8'h11, 32'hA1A2A3A4, 8'hB1);
        chk_frame("t6b", 1, 8'h22, 32'hC1C2C3C4, 8'hB2);
        chk("t6_err_cnt", n_err, 0);
        chk("t6_rxen_empty", bad_empty, 0);
        chk("t6_rxen_b2b", bad_b2b, 0);
        chk("t6_rxen_cnt", n_rxen, 14);

        chk("valid_err_overlap", bad_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
